// File: rtl/pinit_pkg.sv
// Shared types and limits for periph_initiator.
package pinit_pkg;

    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 7;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic        write;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } cmd_t;

    function automatic bit is_pow2(int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/pinit_cmd_fifo.sv
// Synchronous command FIFO feeding the periph_initiator FSM (PINIT_CMD_FIFO_EN builds).
module pinit_cmd_fifo
    import pinit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    cmd_t          mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/periph_initiator.sv
// Single-outstanding peripheral bus initiator with configurable read latency.
// Optional command FIFO enabled by defining PINIT_CMD_FIFO_EN.
module periph_initiator
    import pinit_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        CE,
    output logic        PWE,
    output logic [1:0]  addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
        $fatal(1, "periph_initiator: READ_LAT must be 1..7");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2 || FIFO_DEPTH > 16) begin : g_bad_depth
        $fatal(1, "periph_initiator: FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam int unsigned WAIT_INIT = (READ_LAT > 1) ? READ_LAT - 2 : 0;

    state_e     state_q;
    logic [2:0] wait_cnt_q;
    logic       cur_write_q;
    logic       cmd_avail;
    cmd_t       cmd_head;
    logic       fifo_nonempty;

`ifdef PINIT_CMD_FIFO_EN
    logic                          fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    cmd_t                          fifo_head;

    assign fifo_pop = (state_q == StIdle) && !fifo_empty && !reset;

    pinit_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data ('{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign cmd_ready     = !fifo_full && !reset;
    assign cmd_avail     = !fifo_empty;
    assign cmd_head      = fifo_head;
    assign fifo_nonempty = (fifo_count != '0);
`else
    // Without a FIFO the command is taken straight into the access registers.
    assign cmd_ready     = (state_q == StIdle) && !reset;
    assign cmd_avail     = cmd_valid;
    assign cmd_head      = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign fifo_nonempty = 1'b0;
`endif

    assign busy = (state_q != StIdle) || fifo_nonempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            cur_write_q <= 1'b0;
            CE          <= 1'b0;
            PWE         <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_write   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_avail) begin
                        state_q     <= StAccess;
                        CE          <= 1'b1;
                        PWE         <= cmd_head.write;
                        addr        <= cmd_head.addr;
                        wdata       <= cmd_head.wdata;
                        cur_write_q <= cmd_head.write;
                    end
                end
                StAccess: begin
                    CE  <= 1'b0;
                    PWE <= 1'b0;
                    if (cur_write_q) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_write <= 1'b1;
                    end else if (READ_LAT == 1) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_write <= 1'b0;
                    end else begin
                        state_q    <= StWait;
                        wait_cnt_q <= 3'(WAIT_INIT);
                    end
                end
                StWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata;
                        rsp_write <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
